// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
// Holds the FSM state type and the bit-counter width calculation.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Counter must hold FRAME_LEN-1, which reaches WIDTH when a parity slot exists.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit loadable shift register; sout is the bit currently on the wire.
// Zeros are shifted in so the output settles to 0 once a word has drained.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_pass
          assign shifted[gi] = data_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_pass
          assign shifted[gi] = data_reg[gi+1];
        end
      end
    end

    if (MSB_FIRST) begin : g_out_msb
      assign sout = data_reg[WIDTH-1];
    end else begin : g_out_lsb
      assign sout = data_reg[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= din;
    end else if (shift) begin
      data_reg <= shifted;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and gapless reload.
// Optional even-parity slot after the data bits when PISO_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  piso_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_bit;
  logic             xfer;
  logic             shift_en;
  logic             data_bit;

  assign last_bit   = (state_reg == SHIFT) && (cnt_reg == LAST_CNT);
  assign load_ready = (state_reg == IDLE) || last_bit;
  assign xfer       = load_valid && load_ready && !reset;
  // A reload on the last bit time replaces the shift, keeping the frame gapless.
  assign shift_en   = (state_reg == SHIFT) && !xfer;
  assign busy       = (state_reg == SHIFT);
  assign frame      = (state_reg == SHIFT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (xfer) begin
      state_next = SHIFT;
      cnt_next   = '0;
    end else if (state_reg == SHIFT) begin
      if (last_bit) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_reg (
    .clk  (clk),
    .reset(reset),
    .load (xfer),
    .shift(shift_en),
    .din  (load_data),
    .sout (data_bit)
  );

`ifdef PISO_PARITY_EN
  logic parity_reg;
  logic parity_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_reg <= 1'b0;
    end else if (xfer) begin
      parity_reg <= ^load_data;
    end
  end

  // The data register has drained to zero by the parity slot, so OR-ing is safe.
  assign parity_slot = (state_reg == SHIFT) && (cnt_reg == CNT_W'(WIDTH));
  assign serial_out  = data_bit | (parity_slot & parity_reg);
`else
  assign serial_out = data_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances share
// one stimulus stream; a bit-queue model predicts frame, ready and serial bits.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;

  logic load_ready_m, serial_out_m, frame_m, busy_m;
  logic load_ready_l, serial_out_l, frame_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready_m),
    .serial_out(serial_out_m),
    .frame     (frame_m),
    .busy      (busy_m)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready_l),
    .serial_out(serial_out_l),
    .frame     (frame_l),
    .busy      (busy_l)
  );

  // Bits still to appear on the wire, in transmission order.
  bit q_m[$];
  bit q_l[$];
  int checks = 0;
  int passed = 0;
  int cycle_no = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
  endtask

  function automatic void push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      q_m.push_back(w[WIDTH-1-i]);
      q_l.push_back(w[i]);
    end
`ifdef PISO_PARITY_EN
    q_m.push_back(^w);
    q_l.push_back(^w);
`endif
  endfunction

  // One clock: drive on the falling edge, update the model at the rising edge.
  // A word is taken exactly when nothing of the previous word remains unsent.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, output bit acc);
    @(negedge clk);
    load_valid = v;
    load_data  = d;
    reset      = r;
    @(posedge clk);
    cycle_no++;
    acc = 1'b0;
    if (r) begin
      q_m.delete();
      q_l.delete();
    end else if (v && q_m.size() == 0) begin
      push_word(d);
      acc = 1'b1;
      $display("cycle %0d: word 0x%02h accepted", cycle_no, d);
    end
    started = 1'b1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'b0, acc);
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      step(1'b1, w, 1'b0, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  int  sz;
  bit  em, el;

  // Monitor: compare every cycle against the head of the expected bit queue.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        sz = q_m.size();
        check("frame_msb", 32'(frame_m), 32'(sz > 0));
        check("frame_lsb", 32'(frame_l), 32'(sz > 0));
        check("busy_msb", 32'(busy_m), 32'(sz > 0));
        check("busy_lsb", 32'(busy_l), 32'(sz > 0));
        check("ready_msb", 32'(load_ready_m), 32'(sz <= 1));
        check("ready_lsb", 32'(load_ready_l), 32'(sz <= 1));
        if (sz > 0) begin
          em = q_m.pop_front();
          el = q_l.pop_front();
          check("bit_msb", 32'(serial_out_m), 32'(em));
          check("bit_lsb", 32'(serial_out_l), 32'(el));
        end else begin
          check("idle_out_msb", 32'(serial_out_m), 32'd0);
          check("idle_out_lsb", 32'(serial_out_l), 32'd0);
        end
      end
    end
  end

  initial begin
    bit acc;
    bit r, v;
    // Reset held two cycles with a word offered; it must be ignored.
    step(1'b1, 8'hA5, 1'b1, acc);
    step(1'b1, 8'hA5, 1'b1, acc);
    idle(1);
    // Single words, then drain.
    send(8'hA5);
    idle(FRAME_LEN + 2);
    send(8'h01);
    idle(FRAME_LEN + 2);
    // Back-to-back with valid held high.
    send(8'hFF);
    send(8'h00);
    idle(FRAME_LEN + 2);
    // Abort mid-word, then a clean word.
    send(8'hA5);
    idle(2);
    step(1'b0, WIDTH'($urandom), 1'b1, acc);
    idle(1);
    send(8'h3C);
    idle(FRAME_LEN + 2);
    send(8'h07);
    idle(FRAME_LEN + 2);
    // Random valid, data and occasional reset.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(v, WIDTH'($urandom), r, acc);
    end
    idle(FRAME_LEN + 3);
    check("drain_empty", 32'(q_m.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
